ps2_host_tx: RTL

PS/2 host-to-device transmitter. It sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. It sits beside the existing PS/2 receive path on the same ps_clk/ps_data lines and drives them open-drain through drive-low enables. The top level ties each line as "enable ? 0 : z" with pull-ups.

---
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter, open-drain drive-low outputs
// Optional: define PS2_TX_RETRY_EN to retry a failed frame up to twice before reporting.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps_clk,
  input  logic       ps_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps_clk_drive_low,
  output logic       ps_data_drive_low,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    data_q;
  logic          parity_q;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry_cnt;
`endif

  logic fall, active, timeout_hit, nack;

  assign fall        = clk_prev & ~clk_s2;
  assign active      = (state == S_START) || (state == S_BITS) ||
                       (state == S_ACK) || (state == S_WAIT_IDLE);
  // The inhibit counter is reused as the frame timeout once the clock is released.
  assign timeout_hit = active && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign nack        = (state == S_ACK) && fall && data_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      clk_s1            <= 1'b1;
      clk_s2            <= 1'b1;
      clk_prev          <= 1'b1;
      data_s1           <= 1'b1;
      data_s2           <= 1'b1;
      cnt               <= '0;
      bit_idx           <= '0;
      data_q            <= '0;
      parity_q          <= 1'b0;
      tx_ready          <= 1'b1;
      ps_clk_drive_low  <= 1'b0;
      ps_data_drive_low <= 1'b0;
      tx_done           <= 1'b0;
      tx_err            <= 1'b0;
      err_code          <= 2'b00;
`ifdef PS2_TX_RETRY_EN
      retry_cnt         <= 2'd0;
`endif
    end else begin
      clk_s1   <= ps_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps_data;
      data_s2  <= data_s1;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;

      if (timeout_hit || nack) begin
`ifdef PS2_TX_RETRY_EN
        if (retry_cnt != 2'd2) begin
          retry_cnt         <= retry_cnt + 2'd1;
          state             <= S_INHIBIT;
          cnt               <= '0;
          ps_clk_drive_low  <= 1'b1;
          ps_data_drive_low <= 1'b0;
        end else
`endif
        begin
          state             <= S_IDLE;
          ps_clk_drive_low  <= 1'b0;
          ps_data_drive_low <= 1'b0;
          tx_err            <= 1'b1;
          err_code          <= timeout_hit ? 2'b01 : 2'b10;
        end
      end else begin
        case (state)
          S_IDLE: begin
            // tx_ready lags the return to IDLE by one cycle, so nothing is taken during a pulse.
            tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
              data_q           <= tx_data;
              parity_q         <= ~^tx_data;
              tx_ready         <= 1'b0;
              err_code         <= 2'b00;
              cnt              <= '0;
              ps_clk_drive_low <= 1'b1;
              state            <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry_cnt        <= 2'd0;
`endif
            end
          end
          S_INHIBIT: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(INHIBIT_CYCLES - 2))
              ps_data_drive_low <= 1'b1;
            if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
              ps_clk_drive_low <= 1'b0;
              cnt              <= '0;
              state            <= S_START;
            end
          end
          S_START: begin
            cnt     <= cnt + CW'(1);
            bit_idx <= '0;
            state   <= S_BITS;
          end
          S_BITS: begin
            cnt <= cnt + CW'(1);
            if (fall) begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx < 4'd8) begin
                ps_data_drive_low <= ~data_q[bit_idx[2:0]];
              end else if (bit_idx == 4'd8) begin
                ps_data_drive_low <= ~parity_q;
              end else begin
                ps_data_drive_low <= 1'b0;
                state             <= S_ACK;
              end
            end
          end
          S_ACK: begin
            cnt <= cnt + CW'(1);
            if (fall)
              state <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: begin
            cnt <= cnt + CW'(1);
            if (clk_s2 && data_s2) begin
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
